// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_full_sub.sv
// 1-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, done pulse after WIDTH shifts.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [WIDTH-1:0] diff_shift;
    logic             bin_q;
    logic             d, bout;
    logic             last;

    full_sub u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (bin_q),
        .d    (d),
        .bout (bout)
    );

    // A 1-bit result has no upper bits to shift down.
    generate
        if (WIDTH == 1) begin : g_w1
            assign diff_shift = d;
        end else begin : g_wn
            assign diff_shift = {d, diff[WIDTH-1:1]};
        end
    endgenerate

    assign last = (count_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q    <= '0;
            sb_q    <= '0;
            bin_q   <= 1'b0;
            count_q <= '0;
            diff    <= '0;
            borrow  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        bin_q   <= 1'b0;
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    diff    <= diff_shift;
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    bin_q   <= bout;
                    count_q <= count_q + 1'b1;
                    if (last) borrow <= bout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub at WIDTH=8, 4 and 1.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, borrow1;
    logic [0:0] diff1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );
    serial_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );
    serial_sub #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one 8-bit op; checks done latency, result and borrow.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb);
        int cyc;
        a8 = av; b8 = bv; start8 = 1'b1;
        step();
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 20) begin
            step();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 9);
        chk({tag, "_diff"}, diff8, ed);
        chk({tag, "_borrow"}, borrow8, eb);
        step();
    endtask

    // Runs one op on the 1- or 4-bit instance and checks {borrow,diff} against a-b.
    task automatic op_small(input int unsigned w, input int unsigned av, input int unsigned bv);
        int cyc;
        int unsigned obs, exp;
        logic dn;
        if (w == 1) begin a1 = av[0:0]; b1 = bv[0:0]; start1 = 1'b1; end
        else        begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
        step();
        start1 = 1'b0; start4 = 1'b0;
        cyc = 1;
        dn = (w == 1) ? done1 : done4;
        while (!dn && cyc < 12) begin
            step();
            cyc++;
            dn = (w == 1) ? done1 : done4;
        end
        if (w == 1) obs = {30'd0, borrow1, diff1};
        else        obs = {27'd0, borrow4, diff4};
        exp = (av - bv) & ((32'd1 << (w + 1)) - 1);
        chk($sformatf("w%0d_lat_%0d_%0d", w, av, bv), cyc, w + 1);
        chk($sformatf("w%0d_res_%0d_%0d", w, av, bv), obs, exp);
        step();
    endtask

    initial begin
        // 1: reset and idle
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_out", {busy8, done8, borrow8, diff8}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_out", {busy8, done8, borrow8, diff8}, 0);
        end

        // 2: timing of a single op
        a8 = 8'd100; b8 = 8'd37; start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = 8'd0; b8 = 8'd0;
        for (int i = 0; i < 8; i++) begin
            chk("t2_busy", {busy8, done8}, 2'b10);
            step();
        end
        chk("t2_done", {busy8, done8}, 2'b01);
        chk("t2_diff", diff8, 8'd63);
        chk("t2_borrow", borrow8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold", {busy8, done8, borrow8, diff8}, {3'b000, 8'd63});
        end

        // 3: directed vectors and boundaries
        op8("v5_9",    8'd5,   8'd9,   8'hFC, 1'b1);
        op8("v0_ff",   8'h00,  8'hFF,  8'h01, 1'b1);
        op8("vaa_aa",  8'hAA,  8'hAA,  8'h00, 1'b0);
        op8("vff_0",   8'hFF,  8'h00,  8'hFF, 1'b0);

        // 4: start ignored while busy and in DONE
        a8 = 8'd200; b8 = 8'd1; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step();
        a8 = 8'd3; b8 = 8'd7; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_nodone", {busy8, done8}, 2'b10);
            step();
        end
        chk("t4_done", done8, 1'b1);
        chk("t4_diff", diff8, 8'd199);
        chk("t4_borrow", borrow8, 1'b0);
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("t4_after_done", {busy8, done8, borrow8, diff8}, {3'b000, 8'd199});
        step();
        chk("t4_idle", {busy8, done8, borrow8, diff8}, {3'b000, 8'd199});

        // 5: async reset mid-operation
        a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (3) step();
        chk("t5_busy_pre", busy8, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async", {busy8, done8, borrow8, diff8}, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t5_idle", {busy8, done8, borrow8, diff8}, 0);
        op8("v20_50", 8'd20, 8'd50, 8'hE2, 1'b1);

        // 6: exhaustive small widths
        for (int unsigned x = 0; x < 2; x++)
            for (int unsigned y = 0; y < 2; y++)
                op_small(1, x, y);
        for (int unsigned x = 0; x < 16; x++)
            for (int unsigned y = 0; y < 16; y++)
                op_small(4, x, y);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
